exec_stage: RTL and testbench

//  Operand-read + execute stage of the BatPU2 core; sits between decode and the alu.

---
 rtl/batpu_pkg.sv | 30 +++
 rtl/regfile_2r1w.sv | 41 ++++
 rtl/exec_stage.sv | 102 ++++++++++
 tb/tb_exec_stage.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/batpu_pkg.sv
// BatPU2 shared types for the execute slice.
// Op codes, widths and the EXE stage payload.
package batpu_pkg;

  localparam int REG_COUNT = 16;
  localparam int DATA_W    = 8;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_NOR = 3'd2,
    OP_AND = 3'd3,
    OP_XOR = 3'd4,
    OP_RSH = 3'd5,
    OP_INC = 3'd6,
    OP_DEC = 3'd7
  } alu_op_t;

  typedef logic [3:0]        reg_idx_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef struct packed {
    alu_op_t  op;
    reg_idx_t rd;
    data_t    a;
    data_t    b;
    logic     set_flags;
  } ex_payload_t;

endpackage

// File: rtl/regfile_2r1w.sv
// BatPU2 register file: two comb read ports, one debug read,
// one synchronous write port; r0 is hardwired to zero.
module regfile_2r1w
  import batpu_pkg::*;
#(
  parameter int NREG = REG_COUNT,
  parameter int DW   = DATA_W
) (
  input  logic          clk,
  input  logic          sync_rst,
  input  logic          we,
  input  logic [3:0]    wa,
  input  logic [DW-1:0] wd,
  input  logic [3:0]    ra,
  input  logic [3:0]    rb,
  input  logic [3:0]    rdbg,
  output logic [DW-1:0] da,
  output logic [DW-1:0] db,
  output logic [DW-1:0] ddbg
);

  logic [DW-1:0] mem [NREG];

  // Reset clears every entry; writes to r0 are dropped
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      for (int i = 0; i < NREG; i++)
        mem[i] <= '0;
    end else if (we && wa != 4'd0) begin
      mem[wa] <= wd;
    end
  end

  // Combinational reads, r0 forced to zero
  always_comb begin
    da   = (ra   == 4'd0) ? '0 : mem[ra];
    db   = (rb   == 4'd0) ? '0 : mem[rb];
    ddbg = (rdbg == 4'd0) ? '0 : mem[rdbg];
  end

endmodule

// File: rtl/exec_stage.sv
// BatPU2 operand-read + execute stage.
// Bypassed operand capture into EXE, writeback of alu result/flags.
module exec_stage
  import batpu_pkg::*;
#(
  parameter int REG_COUNT = 16,
  parameter int DATA_W    = 8
) (
  input  logic              clk,
  input  logic              sync_rst,
  input  logic              clk_en,
  input  logic              hold,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [3:0]        in_ra,
  input  logic [3:0]        in_rb,
  input  logic [3:0]        in_rd,
  input  logic              in_set_flags,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_op,
  input  logic [DATA_W-1:0] alu_res,
  input  logic              alu_carry,
  input  logic              alu_zero,
  output logic              wb_valid,
  output logic [3:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              flag_carry,
  output logic              flag_zero,
  input  logic [3:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  ex_payload_t ex;
  logic        ex_valid;
  logic        adv;
  logic [DATA_W-1:0] rf_a;
  logic [DATA_W-1:0] rf_b;
  logic [DATA_W-1:0] opa;
  logic [DATA_W-1:0] opb;

  assign adv      = clk_en & ~hold;
  assign in_ready = ~hold;
  assign wb_valid = ex_valid & adv;
  assign wb_rd    = ex.rd;
  assign wb_data  = alu_res;
  assign alu_a    = ex.a;
  assign alu_b    = ex.b;
  assign alu_op   = ex.op;

  regfile_2r1w #(
    .NREG (REG_COUNT),
    .DW   (DATA_W)
  ) u_rf (
    .clk      (clk),
    .sync_rst (sync_rst),
    .we       (wb_valid),
    .wa       (ex.rd),
    .wd       (alu_res),
    .ra       (in_ra),
    .rb       (in_rb),
    .rdbg     (dbg_addr),
    .da       (rf_a),
    .db       (rf_b),
    .ddbg     (dbg_data)
  );

  // Forward the in-flight result when it targets a source register
  always_comb begin
    opa = rf_a;
    opb = rf_b;
    if (wb_valid && ex.rd != 4'd0 && ex.rd == in_ra)
      opa = alu_res;
    if (wb_valid && ex.rd != 4'd0 && ex.rd == in_rb)
      opb = alu_res;
  end

  // EXE register and flags; everything frozen unless clk_en & !hold
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      ex         <= '0;
      ex_valid   <= 1'b0;
      flag_carry <= 1'b0;
      flag_zero  <= 1'b0;
    end else if (adv) begin
      ex_valid <= in_valid;
      if (in_valid) begin
        ex.op        <= alu_op_t'(in_op);
        ex.rd        <= in_rd;
        ex.a         <= opa;
        ex.b         <= opb;
        ex.set_flags <= in_set_flags;
      end
      if (ex_valid && ex.set_flags) begin
        flag_carry <= alu_carry;
        flag_zero  <= alu_zero;
      end
    end
  end

endmodule

// File: tb/tb_exec_stage.sv
// Scoreboard bench for exec_stage with a behavioural alu
// and an architectural (in-order) register model.
module tb_exec_stage;

  logic       clk = 0;
  logic       sync_rst = 1;
  logic       clk_en = 1;
  logic       hold = 0;
  logic       in_valid = 0;
  logic       in_ready;
  logic [2:0] in_op = 0;
  logic [3:0] in_ra = 0, in_rb = 0, in_rd = 0;
  logic       in_set_flags = 0;
  logic [7:0] alu_a, alu_b;
  logic [2:0] alu_op;
  logic [7:0] alu_res;
  logic       alu_carry, alu_zero;
  logic       wb_valid;
  logic [3:0] wb_rd;
  logic [7:0] wb_data;
  logic       flag_carry, flag_zero;
  logic [3:0] dbg_addr = 0;
  logic [7:0] dbg_data;

  int errors = 0;
  int checks = 0;
  bit done = 0;

  typedef struct {
    logic [3:0] rd;
    logic [7:0] data;
    logic       pc;
    logic       pz;
  } exp_t;

  exp_t q[$];
  logic [7:0] mr [16];
  logic mc, mz;

  exec_stage dut (
    .clk(clk), .sync_rst(sync_rst), .clk_en(clk_en),
    .hold(hold), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_ra(in_ra), .in_rb(in_rb),
    .in_rd(in_rd), .in_set_flags(in_set_flags),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_res(alu_res), .alu_carry(alu_carry),
    .alu_zero(alu_zero), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .wb_data(wb_data),
    .flag_carry(flag_carry), .flag_zero(flag_zero),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // Behavioural alu: returns {carry, result}
  function automatic logic [8:0] alu_f(
    input logic [2:0] op, input logic [7:0] a,
    input logic [7:0] b);
    logic [8:0] r;
    case (op)
      3'd0: r = {1'b0, a} + {1'b0, b};
      3'd1: r = {1'b0, a} + {1'b0, ~b} + 9'd1;
      3'd2: r = {1'b0, ~(a | b)};
      3'd3: r = {1'b0, a & b};
      3'd4: r = {1'b0, a ^ b};
      3'd5: r = {1'b0, a >> 1};
      3'd6: r = {1'b0, a} + 9'd1;
      default: r = {1'b0, a} + 9'h0FF;
    endcase
    return r;
  endfunction

  always_comb begin
    logic [8:0] t;
    t = alu_f(alu_op, alu_a, alu_b);
    alu_res   = t[7:0];
    alu_carry = t[8];
    alu_zero  = (t[7:0] == 8'd0);
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mr[i] = 8'd0;
    mc = 0;
    mz = 0;
    q.delete();
  endtask

  // Drive one cycle; accepted instructions go to the model now
  task automatic step(input bit v, input logic [2:0] op,
                      input logic [3:0] ra, input logic [3:0] rb,
                      input logic [3:0] rd, input bit sf,
                      input bit h, input bit ce);
    exp_t e;
    logic [8:0] t;
    in_valid = v; in_op = op; in_ra = ra; in_rb = rb;
    in_rd = rd; in_set_flags = sf; hold = h; clk_en = ce;
    if (v && !h && ce && !sync_rst) begin
      t = alu_f(op, mr[ra], mr[rb]);
      e.rd = rd; e.data = t[7:0]; e.pc = mc; e.pz = mz;
      q.push_back(e);
      if (rd != 0) mr[rd] = t[7:0];
      if (sf) begin
        mc = t[8];
        mz = (t[7:0] == 8'd0);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [2:0] o, input logic [3:0] rd,
                    input logic [3:0] ra, input logic [3:0] rb,
                    input bit sf);
    step(1, o, ra, rb, rd, sf, 0, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 20) begin
      step(0, 0, 0, 0, 0, 0, 0, 1);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d pending, expected 0", q.size());
    end
  endtask

  task automatic chk_all(input string nm);
    for (int i = 0; i < 16; i++) begin
      dbg_addr = 4'(i);
      #1;
      chk($sformatf("%s r%0d", nm, i), 32'(dbg_data), 32'(mr[i]));
    end
    chk({nm, " carry"}, 32'(flag_carry), 32'(mc));
    chk({nm, " zero"}, 32'(flag_zero), 32'(mz));
  endtask

  task automatic rd_reg(input logic [3:0] r,
                        output logic [7:0] v);
    dbg_addr = r;
    #1;
    v = dbg_data;
  endtask

  // Monitor: pop on every writeback and compare
  always @(negedge clk) begin
    exp_t e;
    if (!done && !sync_rst) begin
      chk("in_ready", 32'(in_ready), 32'(!hold));
    end
    if (!done && wb_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_wb: rd=%0d data=%0h, expected none",
                 wb_rd, wb_data);
      end else begin
        e = q.pop_front();
        chk("wb_rd", 32'(wb_rd), 32'(e.rd));
        chk("wb_data", 32'(wb_data), 32'(e.data));
        chk("pre_carry", 32'(flag_carry), 32'(e.pc));
        chk("pre_zero", 32'(flag_zero), 32'(e.pz));
      end
    end
  end

  initial begin
    logic [7:0] v;
    model_reset();
    sync_rst = 1;
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 1, 1, 1, 0, 0, 0);
    sync_rst = 0;
    model_reset();
    chk("reset wb_valid", 32'(wb_valid), 0);
    chk("reset alu_a", 32'(alu_a), 0);
    chk_all("reset");

    // seed r1=2, r2=5, then r3=r1+r2 and r4=r3+r3 back-to-back
    op(6, 1, 0, 0, 0);
    op(0, 1, 1, 1, 0);
    op(6, 2, 0, 0, 0);
    op(0, 2, 2, 2, 0);
    op(0, 2, 2, 2, 0);
    op(6, 2, 2, 0, 0);
    op(0, 3, 1, 2, 1);
    op(0, 4, 3, 3, 0);
    drain();
    rd_reg(3, v); chk("r3", 32'(v), 7);
    rd_reg(4, v); chk("r4 bypass", 32'(v), 14);
    chk("add carry", 32'(flag_carry), 0);
    chk("add zero", 32'(flag_zero), 0);

    // 0xFF + 1 with flags, then flagless op
    op(7, 5, 0, 0, 0);
    op(6, 6, 0, 0, 0);
    op(0, 5, 5, 6, 1);
    op(0, 7, 1, 2, 0);
    drain();
    rd_reg(5, v); chk("r5 wrap", 32'(v), 0);
    chk("wrap carry", 32'(flag_carry), 1);
    chk("wrap zero", 32'(flag_zero), 1);

    // hold with r8=r1+r2 sitting in EXE
    op(0, 8, 1, 2, 1);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 3, 3, 9, 1, 1, 1);
      chk("hold wb_valid", 32'(wb_valid), 0);
      rd_reg(8, v); chk("hold r8", 32'(v), 0);
      chk("hold carry", 32'(flag_carry), 1);
    end
    drain();
    rd_reg(8, v); chk("r8 after hold", 32'(v), 7);
    chk("post carry", 32'(flag_carry), 0);

    // r0 write of 9 dropped
    op(0, 0, 1, 3, 0);
    drain();
    rd_reg(0, v); chk("r0", 32'(v), 0);

    // reset with r9 in EXE
    op(0, 9, 1, 2, 1);
    sync_rst = 1;
    step(0, 0, 0, 0, 0, 0, 0, 1);
    sync_rst = 0;
    model_reset();
    chk_all("mid reset");

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 9) < 7, 3'($urandom),
           4'($urandom_range(0, 5)), 4'($urandom_range(0, 5)),
           4'($urandom_range(0, 5)), 1'($urandom),
           $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 8);
    end
    drain();
    chk_all("final");

    done = 1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
